negate_seq: RTL and testbench
=============================

Name: negate_seq

Overview:
- Parametrised, multi-cycle two's-complement sign unit for the ALU datapath.
- Supports four modes: pass, negate, absolute value, negative absolute value.
- Inverts the operand, then adds the carry-in one CHUNK-bit slice per cycle, LSB first, so one narrow adder is reused across the full width.
- Valid/ready handshakes on both input and output let the control unit stall it or back-pressure it.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.
- CHUNK, 8, bits processed per cycle; WIDTH must be an integer multiple of CHUNK.
- NCHUNK, WIDTH/CHUNK, derived (localparam); number of processing cycles.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand and op are valid.
- in_ready  out  1  unit can accept an operand.
- a  in  WIDTH  signed operand.
- op  in  2  mode: 00 pass, 01 negate, 10 abs, 11 nabs.
- out_valid  out  1  result, ovf and zero are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  signed result.
- ovf  out  1  result is not representable.
- zero  out  1  result == 0.
- busy  out  1  high in BUSY state.

Behaviour:
- Reset (clr=0, asynchronous), all cleared:
  - state=IDLE
  - result=0, ovf=0, zero=0, out_valid=0, busy=0
  - chunk index=0, carry=0
  - in_ready=1 once clr deasserts.
- States IDLE, BUSY, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE:
  - On in_valid && in_ready, latch a and op, and compute inv:
    - inv = (op==01) | (op==10 & a[WIDTH-1]) | (op==11 & ~a[WIDTH-1]).
  - Set carry=inv, chunk index k=0, go to BUSY.
- BUSY, one slice per cycle:
  - {carry, result[k*CHUNK +: CHUNK]} = (a_slice ^ {CHUNK{inv}}) + carry.
  - k increments each cycle.
  - After slice NCHUNK-1, go to DONE and assert out_valid.
  - Latency: accept edge to out_valid high = NCHUNK cycles.
  - Pass mode takes the same path (inv=0, carry=0), so latency is identical for every op.
- Result flags (valid when out_valid=1, held stable until the handshake):
  - ovf = inv & (a == most-negative value, 1 followed by WIDTH-1 zeros).
  - For that case result = the same value (two's-complement wrap).
  - nabs of most-negative: inv=0, so ovf=0. ovf is never set in pass mode.
  - zero = (result == 0). Negate of 0 gives result 0, zero=1, ovf=0; the final carry-out is discarded.
- DONE:
  - Hold result, ovf and zero until out_valid && out_ready, then go to IDLE.
  - No accept occurs in the same cycle as the output handshake; throughput is one op per NCHUNK+2 cycles minimum.
- Inputs a, op and in_valid are ignored outside IDLE.
- Reset asserted mid-operation aborts the op: no out_valid pulse, all state cleared as above.
- CHUNK==WIDTH is legal: a single BUSY cycle, latency 1.

Test Plan:
- WIDTH=32, CHUNK=8, op=01, a=5, out_ready=1 -> out_valid exactly 4 cycles after the accept edge; result=0xFFFFFFFB, ovf=0, zero=0; in_ready low from the accept edge until the cycle after the output handshake.
- op=10, a=0xFFFFFFF6 -> result=0x0000000A. op=10, a=0x0000000A -> result=0x0000000A. op=11, a=7 -> result=0xFFFFFFF9. op=00, a=0x12345678 -> result unchanged. All with latency 4.
- op=01, a=0x80000000 -> result=0x80000000, ovf=1. op=10 on the same a -> ovf=1. op=11 on the same a -> ovf=0. op=01, a=0 -> result=0, zero=1, ovf=0.
- Back-pressure: out_ready=0 for 6 cycles after out_valid -> result and flags held stable, in_ready=0 throughout, in_valid pulses ignored; out_ready=1 -> IDLE on the next edge, next op accepted.
- Reset: assert clr=0 two cycles into BUSY -> outputs immediately 0, no out_valid; after release, a fresh op=01, a=1 -> 0xFFFFFFFF.
- Parameter sweep: WIDTH=16/CHUNK=16 (latency 1) and WIDTH=64/CHUNK=4 (latency 16) -> random operands and ops match a reference model for result, ovf and zero.

Source files
------------

// File: rtl/negate_seq.sv
// negate_seq -- multi-cycle two's-complement sign unit.
//
// Applies one of four sign modes to a signed operand:
//   op = 00 pass, 01 negate, 10 absolute value, 11 negative absolute value.
// The operand is conditionally inverted and the +1 is rippled in through a
// single CHUNK-bit adder, one slice per cycle, LSB slice first. Every op,
// including pass, takes exactly NCHUNK cycles from accept to out_valid.
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous, active-low reset
//   in_valid   operand a / op are valid
//   in_ready   unit can accept an operand (IDLE only)
//   a          signed operand, WIDTH bits
//   op         sign mode
//   out_valid  result / ovf / zero are valid (DONE only)
//   out_ready  consumer accepts the result
//   result     signed result, WIDTH bits
//   ovf        result is not representable (negating the most-negative value)
//   zero       result == 0
//   busy       high while slices are being processed
//   state_dbg  current FSM state (IDLE=0, BUSY=1, DONE=2) for observation
//
// Handshake semantics: a transfer happens on a rising edge where both valid
// and ready are high. The producer keeps valid and its data stable until that
// edge; ready may depend on state only. out_valid stays high and result/flags
// stay stable until the edge that completes the output transfer. The accept
// and the output transfer never share a cycle, so back-to-back ops are spaced
// at least NCHUNK+2 cycles apart.

module negate_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic             zero,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the slice index at least one bit wide so CHUNK == WIDTH still works.
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] a_q;
    logic             inv_q;
    logic             carry;
    logic [KW-1:0]    k;

    logic             accept;
    logic             last_slice;
    logic             inv_in;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] result_nxt;

    assign state_dbg = state;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_slice = 1'b0;
        case (state)
            IDLE: begin
                // Held low while reset is asserted, so in_ready rises only
                // once clr is released.
                in_ready = clr;
                accept   = in_valid & clr;
                if (accept) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                busy       = 1'b1;
                last_slice = (k == K_LAST);
                if (last_slice) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slice adder
    // ------------------------------------------------------------------
    always_comb begin
        // Invert when the result must carry the opposite sign of a:
        // negate always, abs when a is negative, nabs when a is non-negative.
        inv_in = (op == 2'b01)
               | ((op == 2'b10) &  a[WIDTH-1])
               | ((op == 2'b11) & ~a[WIDTH-1]);

        a_slice    = a_q[int'(k) * CHUNK +: CHUNK];
        // The initial carry equals inv, which supplies the +1 of ~a + 1.
        sum        = {1'b0, a_slice ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry};
        result_nxt = result;
        result_nxt[int'(k) * CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            a_q    <= '0;
            inv_q  <= 1'b0;
            carry  <= 1'b0;
            k      <= '0;
            result <= '0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            inv_q <= inv_in;
            carry <= inv_in;
            k     <= '0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
        end else if (state == BUSY) begin
            result <= result_nxt;
            carry  <= sum[CHUNK];
            k      <= k + 1'b1;
            if (last_slice) begin
                // Only the most-negative value has no positive counterpart;
                // the final carry-out is dropped (wrap), which also makes
                // -0 come out as 0.
                ovf  <= inv_q & (a_q == MOST_NEG);
                zero <= (result_nxt == '0);
                k    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_negate_seq.sv
// Testbench for negate_seq: three instances (32/8, 16/16, 64/4) driven with
// directed and random operations, checked against an arithmetic model.

module tb_negate_seq;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT signals, index 0: W32/C8, 1: W16/C16, 2: W64/C4
    // ------------------------------------------------------------------
    logic        in_valid_v [3];
    logic [63:0] a_v        [3];
    logic [1:0]  op_v       [3];
    logic        out_ready_v[3];
    logic        in_ready_v [3];
    logic        out_valid_v[3];
    logic        ovf_v      [3];
    logic        zero_v     [3];
    logic        busy_v     [3];
    logic [1:0]  st_v       [3];
    logic [63:0] res_v      [3];

    logic [31:0] res_0;
    logic [15:0] res_1;
    logic [63:0] res_2;

    assign res_v[0] = {32'd0, res_0};
    assign res_v[1] = {48'd0, res_1};
    assign res_v[2] = res_2;

    int widths [3] = '{32, 16, 64};
    int nchunks[3] = '{4, 1, 16};

    negate_seq #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .clr(clr),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][31:0]), .op(op_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .result(res_0), .ovf(ovf_v[0]), .zero(zero_v[0]),
        .busy(busy_v[0]), .state_dbg(st_v[0])
    );

    negate_seq #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .clr(clr),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][15:0]), .op(op_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .result(res_1), .ovf(ovf_v[1]), .zero(zero_v[1]),
        .busy(busy_v[1]), .state_dbg(st_v[1])
    );

    negate_seq #(.WIDTH(64), .CHUNK(4)) u_dut64 (
        .clk(clk), .clr(clr),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .op(op_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .result(res_2), .ovf(ovf_v[2]), .zero(zero_v[2]),
        .busy(busy_v[2]), .state_dbg(st_v[2])
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [65:0] exp_q[$];   // {ovf, zero, result}
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [63:0] width_mask(input int w);
        if (w >= 64) return '1;
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference model: take the true mathematical value of the requested
    // operation, then report overflow if it falls outside the signed range
    // of the width, and wrap it to the width for the result.
    function automatic void model(input int w, input logic [63:0] a, input logic [1:0] op,
                                  output logic [63:0] r, output logic o, output logic z);
        logic [65:0]        ext;
        logic signed [65:0] sa, t, lo, hi;
        ext = {2'b00, a} << (66 - w);
        sa  = $signed(ext) >>> (66 - w);
        case (op)
            2'b00:   t = sa;
            2'b01:   t = -sa;
            2'b10:   t = (sa < 0) ? -sa : sa;
            default: t = (sa > 0) ? -sa : sa;
        endcase
        hi = (66'sd1 <<< (w - 1)) - 66'sd1;
        lo = -(66'sd1 <<< (w - 1));
        o  = (t > hi) || (t < lo);
        r  = t[63:0] & width_mask(w);
        z  = (r == 64'd0);
    endfunction

    // ------------------------------------------------------------------
    // Driver: one full operation on DUT d with a given output stall
    // ------------------------------------------------------------------
    task automatic do_op(input int d, input logic [63:0] a, input logic [1:0] op, input int stall);
        int          cnt;
        logic [65:0] e;
        logic [63:0] r, m;
        logic        o, z;
        m   = width_mask(widths[d]);
        cnt = 0;
        while (!in_ready_v[d] && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("in_ready_idle", 64'(in_ready_v[d]), 64'd1);
        in_valid_v[d] = 1'b1;
        a_v[d]        = a & m;
        op_v[d]       = op;
        model(widths[d], a & m, op, r, o, z);
        exp_q.push_back({o, z, r});
        @(posedge clk); #1;   // accept edge
        in_valid_v[d] = 1'b0;
        a_v[d]        = {$urandom, $urandom};
        op_v[d]       = 2'($urandom_range(0, 3));
        cnt = 0;
        while (!out_valid_v[d] && cnt < 200) begin
            check("in_ready_busy", 64'(in_ready_v[d]), 64'd0);
            check("busy_flag", 64'(busy_v[d]), 64'd1);
            // Inputs must be ignored while busy.
            in_valid_v[d] = 1'($urandom_range(0, 1));
            a_v[d]        = {$urandom, $urandom};
            @(posedge clk); #1;
            cnt++;
        end
        in_valid_v[d] = 1'b0;
        check("latency", 64'(cnt), 64'(nchunks[d]));
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check("result", res_v[d], e[63:0]);
        check("ovf", 64'(ovf_v[d]), 64'(e[65]));
        check("zero", 64'(zero_v[d]), 64'(e[64]));
        check("busy_done", 64'(busy_v[d]), 64'd0);
        for (int i = 0; i < stall; i++) begin
            in_valid_v[d] = 1'($urandom_range(0, 1));
            a_v[d]        = {$urandom, $urandom};
            @(posedge clk); #1;
            check("stall_valid", 64'(out_valid_v[d]), 64'd1);
            check("stall_result", res_v[d], e[63:0]);
            check("stall_ovf", 64'(ovf_v[d]), 64'(e[65]));
            check("stall_zero", 64'(zero_v[d]), 64'(e[64]));
            check("stall_in_ready", 64'(in_ready_v[d]), 64'd0);
        end
        in_valid_v[d]  = 1'b0;
        out_ready_v[d] = 1'b1;
        @(posedge clk); #1;   // output handshake edge
        out_ready_v[d] = 1'b0;
        check("post_hs_valid", 64'(out_valid_v[d]), 64'd0);
        check("post_hs_in_ready", 64'(in_ready_v[d]), 64'd1);
    endtask

    function automatic logic [63:0] rand_operand(input int w);
        logic [63:0] m;
        m = width_mask(w);
        case ($urandom_range(0, 6))
            0:       return 64'd1 << (w - 1);            // most negative
            1:       return 64'd0;
            2:       return m;                           // -1
            3:       return m >> 1;                      // most positive
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            a_v[i]         = '0;
            op_v[i]        = 2'b00;
            out_ready_v[i] = 1'b0;
        end
        clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", res_v[0], 64'd0);
        check("rst_ovf", 64'(ovf_v[0]), 64'd0);
        check("rst_zero", 64'(zero_v[0]), 64'd0);
        check("rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("rst_busy", 64'(busy_v[0]), 64'd0);
        check("rst_in_ready", 64'(in_ready_v[0]), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        check("rel_in_ready", 64'(in_ready_v[0]), 64'd1);
        check("rel_in_ready16", 64'(in_ready_v[1]), 64'd1);
        check("rel_in_ready64", 64'(in_ready_v[2]), 64'd1);

        // Directed ops on the 32-bit instance, with an explicit constant
        // check of the headline cases alongside the model.
        do_op(0, 64'h5, 2'b01, 0);
        check("neg5_const", res_v[0], 64'hFFFFFFFB);
        do_op(0, 64'hFFFFFFF6, 2'b10, 0);
        check("abs_neg10_const", res_v[0], 64'h0000000A);
        do_op(0, 64'h0000000A, 2'b10, 1);
        do_op(0, 64'h7, 2'b11, 0);
        check("nabs7_const", res_v[0], 64'hFFFFFFF9);
        do_op(0, 64'h12345678, 2'b00, 0);
        check("pass_const", res_v[0], 64'h12345678);
        do_op(0, 64'h80000000, 2'b01, 0);
        check("neg_min_ovf", 64'(ovf_v[0]), 64'd1);
        do_op(0, 64'h80000000, 2'b10, 0);
        do_op(0, 64'h80000000, 2'b11, 0);
        check("nabs_min_ovf", 64'(ovf_v[0]), 64'd0);
        do_op(0, 64'h0, 2'b01, 0);
        check("neg0_zero", 64'(zero_v[0]), 64'd1);
        // Back-pressure with ignored input pulses.
        do_op(0, 64'h00000123, 2'b01, 6);

        // Reset in the middle of BUSY.
        in_valid_v[0] = 1'b1;
        a_v[0]        = 64'h55;
        op_v[0]       = 2'b01;
        @(posedge clk); #1;   // accept
        in_valid_v[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy", 64'(busy_v[0]), 64'd1);
        clr = 1'b0;
        #1;
        check("abort_result", res_v[0], 64'd0);
        check("abort_busy", 64'(busy_v[0]), 64'd0);
        check("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_valid", 64'(out_valid_v[0]), 64'd0);
        end
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;
        check("abort_state", 64'(st_v[0]), 64'd0);
        do_op(0, 64'h1, 2'b01, 0);
        check("post_abort_const", res_v[0], 64'hFFFFFFFF);

        // Randomized ops on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 40; n++) begin
                do_op(d, rand_operand(widths[d]), 2'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)));
            end
        end

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
